// File: rtl/pipe_stall_ctrl_pkg.sv
// Shared stall-bus definitions for the pipeline: bus width, Stop/NoStop
// levels, hold-state encodings and the per-winner stall patterns.
package pipe_stall_ctrl_pkg;

  localparam int unsigned StallBusW = 6;

  localparam logic Stop   = 1'b1;
  localparam logic NoStop = 1'b0;

  // bit0 PC, bit1 IF, bit2 ID, bit3 EX, bit4 MEM, bit5 WB
  typedef logic [StallBusW-1:0] stall_bus_t;

  typedef enum logic [1:0] {
    StallRun     = 2'd0,
    StallIdHold  = 2'd1,
    StallExHold  = 2'd2,
    StallMemHold = 2'd3
  } stall_state_e;

  // Each pattern holds the winning stage and all earlier stages; the next
  // stage sees NoStop and therefore loads a bubble.
  localparam stall_bus_t StallPatId  = {NoStop, NoStop, NoStop, Stop,   Stop, Stop};
  localparam stall_bus_t StallPatEx  = {NoStop, NoStop, Stop,   Stop,   Stop, Stop};
  localparam stall_bus_t StallPatMem = {NoStop, Stop,   Stop,   Stop,   Stop, Stop};

  function automatic stall_bus_t stall_pattern(input stall_state_e winner);
    stall_bus_t pat;
    pat = '0;
    case (winner)
      StallIdHold:  pat = StallPatId;
      StallExHold:  pat = StallPatEx;
      StallMemHold: pat = StallPatMem;
      default:      pat = '0;
    endcase
    return pat;
  endfunction

endpackage

// File: rtl/pipe_stall_ctrl_sat_counter.sv
// Saturating up-counter with synchronous reset and clear; clear wins over
// increment, increment stops at all-ones.
module sat_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  logic [W-1:0] r_q;

  // Count register: reset/clear to zero, otherwise increment until all-ones.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_q <= '0;
    end else if (inc && (r_q != '1)) begin
      r_q <= r_q + 1'b1;
    end
  end

  assign q = r_q;

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Central pipeline stall controller: fixed-priority arbitration of
// MEM > EX > ID stall requests, StallBus generation, hold-state tracking,
// per-source stall-cycle counters and sticky protocol-error flags.
module pipe_stall_ctrl
  import pipe_stall_ctrl_pkg::*;
#(
  parameter int unsigned EX_TIMEOUT = 64,
  parameter int unsigned CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stallreq_from_id,
  input  logic             stallreq_from_ex,
  input  logic             stallreq_from_mem,
  input  logic             cnt_clr,
  output logic [5:0]       stall,
  output logic [1:0]       stall_state,
  output logic [CNT_W-1:0] cnt_id_stall,
  output logic [CNT_W-1:0] cnt_ex_stall,
  output logic [CNT_W-1:0] cnt_mem_stall,
  output logic             ex_timeout,
  output logic             lu_err
);

  localparam logic [7:0] ExTimeoutLim = 8'(EX_TIMEOUT);

  stall_state_e r_state;
  stall_state_e w_next;
  logic         w_win_id;
  logic         w_win_ex;
  logic         w_win_mem;
  logic [7:0]   r_ex_run;
  logic [7:0]   w_ex_run_inc;
  logic         r_ex_timeout;
  logic         r_lu_err;

  // State register: remembers last cycle's winner.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= StallRun;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state: the winner of this cycle under fixed priority MEM > EX > ID.
  always_comb begin
    w_next = StallRun;
    if (stallreq_from_mem) begin
      w_next = StallMemHold;
    end else if (stallreq_from_ex) begin
      w_next = StallExHold;
    end else if (stallreq_from_id) begin
      w_next = StallIdHold;
    end
  end

  // Output: stall pattern follows the current winner, released during reset.
  always_comb begin
    stall = '0;
    if (!rst) begin
      stall = stall_pattern(w_next);
    end
  end

  assign w_win_id    = (w_next == StallIdHold);
  assign w_win_ex    = (w_next == StallExHold);
  assign w_win_mem   = (w_next == StallMemHold);
  assign stall_state = r_state;

  sat_counter #(.W(CNT_W)) u_cnt_id (
    .clk (clk),
    .rst (rst),
    .clr (cnt_clr),
    .inc (w_win_id),
    .q   (cnt_id_stall)
  );

  sat_counter #(.W(CNT_W)) u_cnt_ex (
    .clk (clk),
    .rst (rst),
    .clr (cnt_clr),
    .inc (w_win_ex),
    .q   (cnt_ex_stall)
  );

  sat_counter #(.W(CNT_W)) u_cnt_mem (
    .clk (clk),
    .rst (rst),
    .clr (cnt_clr),
    .inc (w_win_mem),
    .q   (cnt_mem_stall)
  );

  // The run counter parks at the limit, so the flag is set on the same edge
  // the count first reaches EX_TIMEOUT.
  assign w_ex_run_inc = (r_ex_run == ExTimeoutLim) ? r_ex_run : r_ex_run + 8'd1;

  // EX-run tracking: counts consecutive EX wins, any other winner restarts it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ex_run     <= '0;
      r_ex_timeout <= 1'b0;
    end else if (w_win_ex) begin
      r_ex_run <= w_ex_run_inc;
      if (w_ex_run_inc == ExTimeoutLim) begin
        r_ex_timeout <= 1'b1;
      end
    end else begin
      r_ex_run <= '0;
    end
  end

  // Load-use error: ID winning right after an ID hold means a second bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_lu_err <= 1'b0;
    end else if ((r_state == StallIdHold) && w_win_id) begin
      r_lu_err <= 1'b1;
    end
  end

  assign ex_timeout = r_ex_timeout;
  assign lu_err     = r_lu_err;

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Directed, table-driven bench for pipe_stall_ctrl with 4-bit counters.
module tb_pipe_stall_ctrl;

  localparam int unsigned CntW = 4;

  logic            clk;
  logic            rst;
  logic            req_id;
  logic            req_ex;
  logic            req_mem;
  logic            clr;
  logic [5:0]      stall;
  logic [1:0]      st;
  logic [CntW-1:0] cid;
  logic [CntW-1:0] cex;
  logic [CntW-1:0] cmem;
  logic            to;
  logic            lu;

  int checks;
  int failures;

  pipe_stall_ctrl #(
    .EX_TIMEOUT (64),
    .CNT_W      (CntW)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .stallreq_from_id  (req_id),
    .stallreq_from_ex  (req_ex),
    .stallreq_from_mem (req_mem),
    .cnt_clr           (clr),
    .stall             (stall),
    .stall_state       (st),
    .cnt_id_stall      (cid),
    .cnt_ex_stall      (cex),
    .cnt_mem_stall     (cmem),
    .ex_timeout        (to),
    .lu_err            (lu)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       id;
    logic       ex;
    logic       mem;
    logic       clr;
    logic [5:0] stall;
    logic [1:0] st;
    logic [3:0] cid;
    logic [3:0] cex;
    logic [3:0] cmem;
    logic       to;
    logic       lu;
  } vec_t;

  vec_t vecs[17];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drive inputs on the falling edge, settle briefly.
  task automatic drive(input logic r, input logic i, input logic e, input logic m, input logic c);
    @(negedge clk);
    rst = r; req_id = i; req_ex = e; req_mem = m; clr = c;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_regs(input string tag, input logic [1:0] est, input logic [3:0] ecid,
                          input logic [3:0] ecex, input logic [3:0] ecmem,
                          input logic eto, input logic elu);
    chk({tag, ".state"}, 32'(st), 32'(est));
    chk({tag, ".cnt_id"}, 32'(cid), 32'(ecid));
    chk({tag, ".cnt_ex"}, 32'(cex), 32'(ecex));
    chk({tag, ".cnt_mem"}, 32'(cmem), 32'(ecmem));
    chk({tag, ".ex_timeout"}, 32'(to), 32'(eto));
    chk({tag, ".lu_err"}, 32'(lu), 32'(elu));
  endtask

  initial begin
    checks = 0; failures = 0;
    rst = 1'b1; req_id = 1'b0; req_ex = 1'b0; req_mem = 1'b0; clr = 1'b0;

    //           rst  id   ex   mem  clr  stall       st     cid   cex   cmem  to    lu
    vecs[0]  = '{1'b1,1'b1,1'b1,1'b0,1'b0,6'b000000,2'd0,4'd0,4'd0,4'd0,1'b0,1'b0};
    vecs[1]  = '{1'b0,1'b1,1'b0,1'b0,1'b0,6'b000111,2'd1,4'd1,4'd0,4'd0,1'b0,1'b0};
    vecs[2]  = '{1'b0,1'b0,1'b0,1'b0,1'b0,6'b000000,2'd0,4'd1,4'd0,4'd0,1'b0,1'b0};
    vecs[3]  = '{1'b0,1'b0,1'b1,1'b0,1'b0,6'b001111,2'd2,4'd1,4'd1,4'd0,1'b0,1'b0};
    vecs[4]  = '{1'b0,1'b1,1'b1,1'b0,1'b0,6'b001111,2'd2,4'd1,4'd2,4'd0,1'b0,1'b0};
    vecs[5]  = '{1'b0,1'b1,1'b1,1'b1,1'b0,6'b011111,2'd3,4'd1,4'd2,4'd1,1'b0,1'b0};
    vecs[6]  = '{1'b0,1'b1,1'b0,1'b1,1'b0,6'b011111,2'd3,4'd1,4'd2,4'd2,1'b0,1'b0};
    vecs[7]  = '{1'b0,1'b1,1'b0,1'b0,1'b0,6'b000111,2'd1,4'd2,4'd2,4'd2,1'b0,1'b0};
    vecs[8]  = '{1'b0,1'b0,1'b0,1'b0,1'b0,6'b000000,2'd0,4'd2,4'd2,4'd2,1'b0,1'b0};
    vecs[9]  = '{1'b0,1'b0,1'b0,1'b1,1'b0,6'b011111,2'd3,4'd2,4'd2,4'd3,1'b0,1'b0};
    vecs[10] = '{1'b0,1'b0,1'b1,1'b0,1'b1,6'b001111,2'd2,4'd0,4'd0,4'd0,1'b0,1'b0};
    vecs[11] = '{1'b0,1'b0,1'b0,1'b0,1'b0,6'b000000,2'd0,4'd0,4'd0,4'd0,1'b0,1'b0};
    vecs[12] = '{1'b1,1'b0,1'b0,1'b1,1'b0,6'b000000,2'd0,4'd0,4'd0,4'd0,1'b0,1'b0};
    vecs[13] = '{1'b0,1'b1,1'b1,1'b1,1'b0,6'b011111,2'd3,4'd0,4'd0,4'd1,1'b0,1'b0};
    vecs[14] = '{1'b0,1'b1,1'b1,1'b1,1'b0,6'b011111,2'd3,4'd0,4'd0,4'd2,1'b0,1'b0};
    vecs[15] = '{1'b0,1'b1,1'b1,1'b1,1'b0,6'b011111,2'd3,4'd0,4'd0,4'd3,1'b0,1'b0};
    vecs[16] = '{1'b0,1'b0,1'b0,1'b0,1'b0,6'b000000,2'd0,4'd0,4'd0,4'd3,1'b0,1'b0};

    for (int v = 0; v < 17; v++) begin
      drive(vecs[v].rst, vecs[v].id, vecs[v].ex, vecs[v].mem, vecs[v].clr);
      chk($sformatf("v%0d.stall", v), 32'(stall), 32'(vecs[v].stall));
      tick();
      chk_regs($sformatf("v%0d", v), vecs[v].st, vecs[v].cid, vecs[v].cex,
               vecs[v].cmem, vecs[v].to, vecs[v].lu);
    end

    // Repeated load-use: sticky through cnt_clr, cleared by rst.
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0); tick();
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0); tick();
    chk_regs("lu1", 2'd1, 4'd1, 4'd0, 4'd0, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0); tick();
    chk_regs("lu2", 2'd1, 4'd2, 4'd0, 4'd0, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1); tick();
    chk_regs("lu_clr", 2'd0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b1);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0); tick();
    chk_regs("lu_rst", 2'd0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0);

    // Counter saturation at all-ones, then clear beats a concurrent increment.
    for (int k = 0; k < 20; k++) begin
      drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0); tick();
    end
    chk_regs("sat20", 2'd3, 4'd0, 4'd0, 4'd15, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1); tick();
    chk_regs("sat_clr", 2'd3, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0);

    // EX runs of 63, an idle gap, and 63 again must not time out.
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0); tick();
    for (int k = 0; k < 63; k++) begin
      drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0); tick();
    end
    chk("to63a", 32'(to), 32'd0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0); tick();
    for (int k = 0; k < 63; k++) begin
      drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0); tick();
    end
    chk("to63b", 32'(to), 32'd0);
    // A MEM preemption also restarts the run.
    drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0); tick();
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0); tick();
    chk("to_preempt", 32'(to), 32'd0);

    // 64 consecutive EX wins set the flag exactly at the 64th edge.
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0); tick();
    for (int k = 0; k < 63; k++) begin
      drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0); tick();
    end
    chk("to_edge63", 32'(to), 32'd0);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0); tick();
    chk_regs("to_edge64", 2'd2, 4'd0, 4'd15, 4'd0, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1); tick();
    chk_regs("to_clr", 2'd0, 4'd0, 4'd0, 4'd0, 1'b1, 1'b0);

    // Reset during an EX stall releases the bus at once.
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("mid_ex.stall", 32'(stall), 32'h0f);
    tick();
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("mid_rst.stall", 32'(stall), 32'h00);
    tick();
    chk_regs("mid_rst", 2'd0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0); tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipe_stall_ctrl.md
# pipe_stall_ctrl

Central stall controller for the five-stage pipeline. It arbitrates the stall requests raised by ID (load-use), EX (multi-cycle unit busy) and MEM (data SRAM not ready), and drives the shared `StallBus` into PC/IF/ID/EX/MEM/WB. It tracks the holding source in a small state machine, keeps saturating per-source stall-cycle counters, and raises sticky protocol-error flags: EX-stall timeout and a repeated load-use request.

## Interface
- `EX_TIMEOUT`, default 64: consecutive EX-won stall cycles that set `ex_timeout`; legal range 2..255.
- `CNT_W`, default 32: width of each stall-cycle counter.

- `clk`  in  1  system clock.
- `rst`  in  1  synchronous, active-high reset.
- `stallreq_from_id`  in  1  load-use request from ID. Combinational in ID.
- `stallreq_from_ex`  in  1  EX multi-cycle unit busy.
- `stallreq_from_mem`  in  1  data SRAM not ready.
- `cnt_clr`  in  1  synchronous clear of all three counters.
- `stall`  out  `StallBus` (6)  bit0 PC, bit1 IF, bit2 ID, bit3 EX, bit4 MEM, bit5 WB; `Stop` = 1.
- `stall_state`  out  2  registered winner of the previous cycle: 0 RUN, 1 ID_HOLD, 2 EX_HOLD, 3 MEM_HOLD.
- `cnt_id_stall`, `cnt_ex_stall`, `cnt_mem_stall`  out  CNT_W each  cycles won by each source.
- `ex_timeout`  out  1  sticky; EX won EX_TIMEOUT consecutive cycles.
- `lu_err`  out  1  sticky; ID won two consecutive cycles.

## Operation
- Winner selection is fixed priority: MEM > EX > ID > none.
- `stall` is combinational from the current-cycle requests:
  - MEM wins: 6'b011111.
  - EX wins: 6'b001111.
  - ID wins: 6'b000111.
  - No request: 6'b000000.
  - The pattern always holds the winning stage and every earlier stage, and lets the next stage receive a bubble, as the stage registers already expect (stall[n]=Stop with stall[n+1]=NoStop loads a bubble).
- While `rst`=1, `stall` is forced to 0 regardless of the requests.
- FSM state register: next state = winner of this cycle (RUN when there is no request). Every transition is legal, including direct MEM_HOLD→ID_HOLD.
- Counters: at each edge, the winner's counter increments by 1 and saturates at all-ones; the other counters hold. Losing requests are not counted.
- `cnt_clr`=1 zeroes all three counters at the edge and takes precedence over a same-cycle increment.
- Timeout: an 8-bit run counter increments while EX wins. It clears on any cycle EX does not win, including a cycle MEM preempts. When the counter reaches EX_TIMEOUT, `ex_timeout` sets and stays set until `rst`; the run counter saturates. `cnt_clr` does not clear `ex_timeout`.
- `lu_err` sets when `stall_state`==ID_HOLD and ID wins again. A correct load-use needs exactly one bubble. It is cleared only by `rst`.

## Timing
- `stall` has zero latency from the requests: it is combinational, same cycle.
- `stall_state`, the counters and the flags update one cycle after the cycle they describe.
- Reset values: `stall_state`=RUN (0), all counters 0, `ex_timeout`=0, `lu_err`=0, run counter 0.
- A reset asserted mid-stall releases the stall in that same cycle and returns the FSM to RUN at the edge.
- When requests arrive simultaneously, only the winner counts and only the winner advances the FSM.
- With EX_TIMEOUT=N and EX continuously winning from cycle 0, `ex_timeout` is observed high after edge N.

## Structure
- Extend the shared defines header with:
  - State encodings `StallRun`, `StallIdHold`, `StallExHold`, `StallMemHold`.
  - Stall patterns `StallPatId`, `StallPatEx`, `StallPatMem`.
- Reuse the existing `StallBus`, `Stop` and `NoStop` defines.
- One sub-module, `sat_counter`:
  - Parameter W; inputs `clk`, `rst`, `clr`, `inc`; output `q`.
  - Increment saturates at all-ones; `clr` takes precedence over `inc`.
  - Instantiated three times for the stall counters. The timeout run counter is inline.
- Estimated size: 150–250 lines of RTL.

## Test plan
- Single ID request for 1 cycle → `stall`=6'b000111 that cycle; next cycle `stall_state`=1, `cnt_id_stall`=1, `lu_err`=0.
- ID, EX and MEM all asserted for 3 cycles → `stall`=6'b011111 each cycle; `cnt_mem_stall`=3, other counters 0, `stall_state`=3.
- EX held 64 cycles (EX_TIMEOUT=64) → `ex_timeout` rises after the 64th edge. Repeat with 63 cycles, one idle cycle, then 63 cycles → `ex_timeout` stays 0.
- ID asserted 2 consecutive cycles → `lu_err`=1 after the 2nd edge, still set after `cnt_clr`, cleared only by `rst`.
- Preload a counter near saturation (CNT_W=4): 20 MEM cycles → `cnt_mem_stall`=15. `cnt_clr` with a concurrent MEM request → counter 0.
- `rst` asserted during EX stall → `stall`=0 the same cycle; after the edge all outputs are at reset values.
